arch_state_sequencer: RTL and testbench
=======================================

Name: arch_state_sequencer

Overview:
Hardware controller that injects a checkpointed architectural state (XPRs, FPRs, CSRs, PC) into a held-in-reset core before releasing it. It consumes a valid/ready stream of state records from a loader (DPI bridge or TSI-side buffer) and sequences them onto a single shared register-write port. It owns the core reset line, keeping the core in reset until every record is committed, then releases it after a programmable settle delay. It sits in the test harness between the state-record source and the tile's debug/state-write hooks.

Parameters:
XLEN, 64, data width of every record and write port
ADDR_W, 12, register/CSR address width (CSR number fits in 12 bits)
ACK_TIMEOUT, 16, max cycles waiting for wr_ack before error (>=1)
RELEASE_CYCLES, 4, cycles core_reset stays high after last commit (>=1)
CNT_W, 8, width of committed-write counter

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a load sequence (ignored unless IDLE)
in_valid  in  1  record valid
in_ready  out  1  record accepted when in_valid&&in_ready
in_kind  in  3  0=XPR,1=FPR,2=CSR,3=PC,4=END,5..7 illegal
in_addr  in  ADDR_W  register index / CSR number
in_data  in  XLEN  value
wr_valid  out  1  write request to core state port
wr_target  out  2  0=XPR,1=FPR,2=CSR
wr_addr  out  ADDR_W  write address
wr_data  out  XLEN  write data
wr_ack  in  1  target has committed the write
pc_valid  out  1  one-cycle pulse with pc_value at release
pc_value  out  XLEN  PC to start from
core_reset  out  1  reset to core; high until release
busy  out  1  high in any state except IDLE/DONE/ERROR
done  out  1  sticky: sequence completed
error  out  1  sticky: sequence aborted
err_code  out  2  0=none,1=illegal kind,2=ack timeout,3=bad index
write_count  out  CNT_W  writes committed this sequence (saturating)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; core_reset=1; in_ready=0; wr_valid=0; pc_valid=0; pc_value=0; busy=0; done=0; error=0; err_code=0; write_count=0. Reset mid-sequence aborts immediately; core_reset stays 1.
- States: IDLE, ACCEPT, WRITE, RELEASE, DONE, ERROR.
- IDLE: core_reset=1. start -> ACCEPT; clear done, error, err_code, write_count, pc latch (pc_value=0).
- ACCEPT: in_ready=1. On handshake, decode in_kind:
  - XPR, in_addr==0: dropped, stay ACCEPT, no write, count unchanged.
  - XPR/FPR with in_addr>31: err_code=3 -> ERROR.
  - XPR(1..31)/FPR(0..31)/CSR: latch target/addr/data, -> WRITE next cycle.
  - PC: latch pc_value, stay ACCEPT; last PC record wins.
  - END -> RELEASE, load release counter = RELEASE_CYCLES.
  - 5..7: err_code=1 -> ERROR.
- WRITE: in_ready=0; wr_valid=1 with stable target/addr/data until wr_ack sampled high. wr_ack in same cycle wr_valid first asserts counts. On ack: write_count+=1 (saturate at 2^CNT_W-1), wr_valid drops next cycle, -> ACCEPT. Timeout counter starts at 0 on WRITE entry, increments each cycle without ack; reaching ACK_TIMEOUT without ack -> err_code=2, ERROR. wr_ack outside WRITE ignored.
- Throughput: one committed write per 2 cycles minimum (accept, write+ack).
- RELEASE: core_reset=1, count down; when counter hits 0: core_reset=0 same-cycle transition to DONE, pc_valid=1 for exactly that one cycle with pc_value.
- DONE: done=1, core_reset=0, busy=0; start ignored. Only reset returns to IDLE.
- ERROR: error=1, core_reset=1 held forever, wr_valid=0, in_ready=0; start ignored until reset.
- start while busy: ignored. in_valid in IDLE/WRITE/RELEASE: not accepted (in_ready=0).
- busy=1 exactly in ACCEPT, WRITE, RELEASE.

Test Plan:
- Basic load: start; records XPR1=0x11, FPR3=0x3F80_0000, CSR 0x305=0x8000_0100, PC=0x8000_0000, END; wr_ack one cycle after wr_valid -> three writes with exact target/addr/data, write_count=3, core_reset falls 4 cycles after END accept, pc_valid pulse with 0x8000_0000, done=1.
- x0 and duplicate PC: XPR0=0xDEAD, PC=0x1000, PC=0x2000, END -> no wr_valid, write_count=0, pc_value=0x2000.
- Ack timeout: CSR 0x300 record, wr_ack never asserted -> after 16 cycles in WRITE, error=1, err_code=2, wr_valid=0, core_reset stays 1; later start ignored.
- Illegal input: kind=6 -> err_code=1; FPR addr=32 -> err_code=3; no writes issued.
- Backpressure/same-cycle ack: in_valid toggling randomly, wr_ack same cycle as wr_valid -> no lost/duplicated records, write_count equals legal record count.
- Reset mid-WRITE: assert reset while wr_valid=1 -> next cycle IDLE, all outputs at reset values, core_reset=1; new start completes normally.

Source files
------------

// File: rtl/arch_state_sequencer.sv
// Injects checkpointed architectural state into a core held in reset, one record at a time
// over a shared write port, then releases the core after a programmable settle delay.
module arch_state_sequencer #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned ACK_TIMEOUT    = 16,
  parameter int unsigned RELEASE_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_data,
  output logic              wr_valid,
  output logic [1:0]        wr_target,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  input  logic              wr_ack,
  output logic              pc_valid,
  output logic [XLEN-1:0]   pc_value,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  write_count
);

  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RelW = $clog2(RELEASE_CYCLES + 1);

  localparam logic [2:0] KindXpr = 3'd0;
  localparam logic [2:0] KindFpr = 3'd1;
  localparam logic [2:0] KindCsr = 3'd2;
  localparam logic [2:0] KindPc  = 3'd3;
  localparam logic [2:0] KindEnd = 3'd4;

  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrIndex   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StWrite,
    StRelease,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [RelW-1:0]     rel_q, rel_d;
  logic [1:0]          err_q, err_d;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    rel_d      = rel_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    wr_valid   = 1'b0;
    pc_valid   = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccept;
          err_d   = 2'd0;
          cnt_d   = '0;
          pc_d    = '0;
        end
      end

      StAccept: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          case (in_kind)
            KindXpr, KindFpr, KindCsr: begin
              if (in_kind != KindCsr && in_addr > ADDR_W'(31)) begin
                err_d   = ErrIndex;
                state_d = StError;
              end else if (!(in_kind == KindXpr && in_addr == '0)) begin
                // x0 is hardwired zero in the core, so its record is silently dropped.
                tgt_d   = in_kind[1:0];
                addr_d  = in_addr;
                data_d  = in_data;
                tmo_d   = '0;
                state_d = StWrite;
              end
            end
            KindPc:  pc_d = in_data;
            KindEnd: begin
              rel_d   = RelW'(RELEASE_CYCLES);
              state_d = StRelease;
            end
            default: begin
              err_d   = ErrIllegal;
              state_d = StError;
            end
          endcase
        end
      end

      StWrite: begin
        wr_valid = 1'b1;
        busy     = 1'b1;
        if (wr_ack) begin
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          state_d = StAccept;
        end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
          err_d   = ErrTimeout;
          state_d = StError;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StRelease: begin
        busy = 1'b1;
        if (rel_q == '0) begin
          core_reset = 1'b0;
          pc_valid   = 1'b1;
          state_d    = StDone;
        end else begin
          rel_d = rel_q - 1'b1;
        end
      end

      StDone:  core_reset = 1'b0;

      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rel_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
    end
  end

  assign wr_target   = tgt_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign pc_value    = pc_q;
  assign done        = (state_q == StDone);
  assign error       = (state_q == StError);
  assign err_code    = err_q;
  assign write_count = cnt_q;

endmodule

// File: tb/tb_arch_state_sequencer.sv
// Self-checking bench for arch_state_sequencer: decode vector table, scoreboarded write
// stream, and hand-written sequences for release timing, timeout and mid-write reset.
module tb_arch_state_sequencer;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [XLEN-1:0]   in_data = '0;
  logic              wr_valid;
  logic [1:0]        wr_target;
  logic [ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              wr_ack;
  logic              pc_valid;
  logic [XLEN-1:0]   pc_value;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  write_count;

  arch_state_sequencer #(
    .XLEN          (64),
    .ADDR_W        (12),
    .ACK_TIMEOUT   (16),
    .RELEASE_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .wr_valid   (wr_valid),
    .wr_target  (wr_target),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .pc_valid   (pc_valid),
    .pc_value   (pc_value),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .write_count(write_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]        tgt;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  typedef struct {
    logic [2:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    logic [1:0]        exp_err;
    int                exp_wc;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  got_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_mode = 1;  // 0: never, 1: same cycle as wr_valid, 2: one cycle later
  logic prev_wv = 1'b0;
  int   pc_pulses = 0;
  logic [XLEN-1:0] last_pc = '0;

  // Ack responder and commit monitor; acts on the falling edge so the DUT sees a settled ack.
  always @(negedge clock) begin
    case (ack_mode)
      0:       wr_ack = 1'b0;
      1:       wr_ack = wr_valid;
      default: wr_ack = wr_valid && prev_wv;
    endcase
    prev_wv = wr_valid;
    if (!reset && wr_valid && wr_ack) got_q.push_back({wr_target, wr_addr, wr_data});
    if (!reset && pc_valid) begin
      pc_pulses++;
      last_pc = pc_value;
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_write(input logic [2:0] k, input logic [ADDR_W-1:0] a);
    return (k == 3'd0 && a != 0 && a < 32) || (k == 3'd1 && a < 32) || (k == 3'd2);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    pc_pulses = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [ADDR_W-1:0] a,
                      input logic [XLEN-1:0] d, input int gap);
    int n;
    bit ok;
    n = (gap > 0) ? $urandom_range(0, gap) : 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_kind  = k;
    in_addr  = a;
    in_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL handshake_timeout: got no in_ready expected accept of kind %0d", k);
    end else if (is_write(k, a)) begin
      exp_q.push_back({k[1:0], a, d});
    end
  endtask

  task automatic wait_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = done || error;
      if (!ok) begin
        @(posedge clock);
        #1;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL end_timeout: got done=%0b error=%0b expected one of them", done, error);
    end
  endtask

  task automatic check_writes(input string name);
    int n;
    chk({name, "_write_qty"}, XLEN'(got_q.size()), XLEN'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_write%0d: got tgt=%0d addr=0x%0h data=0x%0h expected tgt=%0d addr=0x%0h data=0x%0h",
                 name, i, got_q[i].tgt, got_q[i].addr, got_q[i].data,
                 exp_q[i].tgt, exp_q[i].addr, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[10];
    logic [2:0]        k;
    logic [ADDR_W-1:0] a;
    logic [XLEN-1:0]   d;
    logic [XLEN-1:0]   exp_pc;
    int                exp_wc;

    vecs[0] = '{3'd6, 12'd1,     64'h1, 2'd1, 0};
    vecs[1] = '{3'd1, 12'd32,    64'h2, 2'd3, 0};
    vecs[2] = '{3'd0, 12'd40,    64'h3, 2'd3, 0};
    vecs[3] = '{3'd7, 12'd2,     64'h4, 2'd1, 0};
    vecs[4] = '{3'd5, 12'd3,     64'h5, 2'd1, 0};
    vecs[5] = '{3'd0, 12'd31,    64'hA5A5_0000_0000_5A5A, 2'd0, 1};
    vecs[6] = '{3'd1, 12'd0,     64'h3F80_0000, 2'd0, 1};
    vecs[7] = '{3'd2, 12'hFFF,   64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1};
    vecs[8] = '{3'd0, 12'd0,     64'hDEAD, 2'd0, 0};
    vecs[9] = '{3'd2, 12'h040,   64'h1234_5678, 2'd0, 1};

    // Reset state
    do_reset();
    chk("rst_core_reset", XLEN'(core_reset), 1);
    chk("rst_in_ready", XLEN'(in_ready), 0);
    chk("rst_wr_valid", XLEN'(wr_valid), 0);
    chk("rst_busy", XLEN'(busy), 0);
    chk("rst_done_error", XLEN'({done, error, err_code}), 0);
    chk("rst_count_pc", XLEN'(write_count) | pc_value, 0);

    // Basic load with delayed ack and exact release timing
    ack_mode = 2;
    pulse_start();
    chk("basic_busy", XLEN'(busy), 1);
    send(3'd0, 12'd1,    64'h11, 0);
    send(3'd1, 12'd3,    64'h3F80_0000, 0);
    send(3'd2, 12'h305,  64'h8000_0100, 0);
    send(3'd3, 12'd0,    64'h8000_0000, 0);
    send(3'd4, 12'd0,    64'h0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_core_reset_hold%0d", i), XLEN'(core_reset), 1);
      @(posedge clock);
      #1;
    end
    chk("basic_core_reset_fall", XLEN'(core_reset), 0);
    chk("basic_pc_valid", XLEN'(pc_valid), 1);
    chk("basic_pc_value", pc_value, 64'h8000_0000);
    @(posedge clock);
    #1;
    chk("basic_done", XLEN'({done, busy, pc_valid, core_reset}), 4'b1000);
    chk("basic_write_count", XLEN'(write_count), 3);
    chk("basic_pc_pulses", XLEN'(pc_pulses), 1);
    check_writes("basic");
    pulse_start();
    chk("basic_start_ignored", XLEN'({done, busy}), 2'b10);

    // x0 drop and last PC wins
    do_reset();
    ack_mode = 1;
    pulse_start();
    send(3'd0, 12'd0, 64'hDEAD, 0);
    send(3'd3, 12'd0, 64'h1000, 0);
    send(3'd3, 12'd0, 64'h2000, 0);
    chk("x0_pc_latched", pc_value, 64'h2000);
    send(3'd4, 12'd0, 64'h0, 0);
    wait_end();
    chk("x0_done", XLEN'(done), 1);
    chk("x0_write_count", XLEN'(write_count), 0);
    chk("x0_pc_pulse", last_pc, 64'h2000);
    check_writes("x0");

    // Decode table
    for (int v = 0; v < 10; v++) begin
      do_reset();
      ack_mode = 1;
      pulse_start();
      send(vecs[v].kind, vecs[v].addr, vecs[v].data, 0);
      if (vecs[v].exp_err == 2'd0) send(3'd4, 12'd0, 64'h0, 0);
      wait_end();
      chk($sformatf("vec%0d_error", v), XLEN'(error), XLEN'(vecs[v].exp_err != 0));
      chk($sformatf("vec%0d_err_code", v), XLEN'(err_code), XLEN'(vecs[v].exp_err));
      chk($sformatf("vec%0d_count", v), XLEN'(write_count), XLEN'(vecs[v].exp_wc));
      chk($sformatf("vec%0d_core_reset", v), XLEN'(core_reset), XLEN'(vecs[v].exp_err != 0));
      check_writes($sformatf("vec%0d", v));
    end

    // Ack timeout
    do_reset();
    ack_mode = 0;
    pulse_start();
    send(3'd2, 12'h300, 64'hCAFE, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tmo_wait%0d", i), XLEN'({wr_valid, error}), 2'b10);
      @(posedge clock);
      #1;
    end
    chk("tmo_error", XLEN'({error, err_code}), 3'b110);
    chk("tmo_outputs", XLEN'({wr_valid, core_reset, in_ready, busy}), 4'b0100);
    pulse_start();
    @(posedge clock);
    #1;
    chk("tmo_start_ignored", XLEN'({error, busy, in_ready, core_reset}), 4'b1001);
    chk("tmo_no_commit", XLEN'(got_q.size()), 0);
    exp_q.delete();

    // Backpressure with random gaps and same-cycle ack
    do_reset();
    ack_mode = 1;
    exp_pc = '0;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      k = 3'($urandom_range(0, 3));
      a = ADDR_W'($urandom_range(0, 31));
      d = {$urandom, $urandom};
      if (k == 3'd3) exp_pc = d;
      send(k, a, d, 3);
    end
    exp_wc = exp_q.size();
    send(3'd4, 12'd0, 64'h0, 2);
    wait_end();
    chk("bp_done", XLEN'(done), 1);
    chk("bp_write_count", XLEN'(write_count), XLEN'(exp_wc));
    chk("bp_pc", pc_value, exp_pc);
    check_writes("bp");

    // Reset in the middle of a write
    do_reset();
    ack_mode = 0;
    pulse_start();
    send(3'd3, 12'd0, 64'h1234, 0);
    send(3'd0, 12'd5, 64'h55, 0);
    chk("mid_wr_valid", XLEN'(wr_valid), 1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("mid_ctl", XLEN'({wr_valid, in_ready, busy, core_reset}), 4'b0001);
    chk("mid_status", XLEN'({done, error, err_code}), 0);
    chk("mid_count_pc", XLEN'(write_count) | pc_value, 0);
    chk("mid_no_commit", XLEN'(got_q.size()), 0);
    exp_q.delete();
    ack_mode = 1;
    pulse_start();
    send(3'd0, 12'd7, 64'h77, 0);
    send(3'd4, 12'd0, 64'h0, 0);
    wait_end();
    chk("mid_restart_done", XLEN'({done, core_reset}), 2'b10);
    chk("mid_restart_count", XLEN'(write_count), 1);
    check_writes("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
